// File: rtl/poly_pkg.sv
// Shared definitions for the polynomial coefficient streamer: mode encoding,
// FSM states and the two's-complement negation helper.
package poly_pkg;

  localparam logic MODE_CYCLIC     = 1'b0;
  localparam logic MODE_NEGACYCLIC = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRIME,
    ST_STREAM,
    ST_FIN
  } state_t;

  localparam int NEG_MAX_W = 64;

  // Callers zero-extend into this width and keep the low W bits, so the most
  // negative W-bit value wraps onto itself.
  function automatic logic [NEG_MAX_W-1:0] neg_coeff(input logic [NEG_MAX_W-1:0] v);
    return ~v + NEG_MAX_W'(1);
  endfunction

endpackage

// File: rtl/poly_coeff_streamer_if.sv
// Handshake and operand bus between the coefficient streamer and its user.
interface poly_coeff_streamer_if #(
  parameter int N = 4,
  parameter int W = 2
);
  localparam int CW = $clog2(N);

  logic           start;
  logic           mode;
  logic [N*W-1:0] data_in;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_data;
  logic [CW-1:0]  out_round;
  logic [CW-1:0]  out_beat;
  logic           out_last;
  logic           busy;
  logic           done;

  modport master (
    output start, mode, data_in, out_ready,
    input  out_valid, out_data, out_round, out_beat, out_last, busy, done
  );

  modport slave (
    input  start, mode, data_in, out_ready,
    output out_valid, out_data, out_round, out_beat, out_last, busy, done
  );

endinterface

// File: rtl/coeff_rot_reg.sv
// N x W coefficient register with parallel load and a one-position rotate;
// the wrapped coefficient is optionally negated (multiplication by x mod x^N+1).
module coeff_rot_reg
  import poly_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load_en,
  input  logic [N*W-1:0] load_data,
  input  logic           rot_en,
  input  logic           neg_en,
  output logic [N*W-1:0] q
);

  logic [W-1:0] tail;
  logic [W-1:0] wrap_val;

  assign tail     = q[(N-1)*W +: W];
  assign wrap_val = neg_en ? W'(neg_coeff(NEG_MAX_W'(tail))) : tail;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load_en) begin
      q <= load_data;
    end else if (rot_en) begin
      q <= {q[(N-1)*W-1:0], wrap_val};
    end
  end

endmodule

// File: rtl/poly_coeff_streamer.sv
// Coefficient shift-register unit: CSR1 steps b*x^r once per round while CSR2
// streams the current row, highest coefficient first, one beat per handshake.
module poly_coeff_streamer
  import poly_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  poly_coeff_streamer_if.slave  bus
);

  localparam int            CW   = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N-1);

  state_t         state, state_nxt;
  logic           mode_q;
  logic [CW-1:0]  round_q, round_nxt;
  logic [CW-1:0]  beat_q, beat_nxt;
  logic [N*W-1:0] csr1_q, csr2_q;
  logic           accept;
  logic           load_csr1;
  logic           advance_row;
  logic           rot_csr2;

  assign accept = (state == ST_STREAM) && bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      mode_q  <= MODE_CYCLIC;
      round_q <= '0;
      beat_q  <= '0;
    end else begin
      state   <= state_nxt;
      round_q <= round_nxt;
      beat_q  <= beat_nxt;
      if (load_csr1) begin
        mode_q <= bus.mode;
      end
    end
  end

  // advance_row hands the next rotated row to CSR2 and steps CSR1 in the same
  // edge, which is what removes the bubble between rounds.
  always_comb begin
    state_nxt   = state;
    round_nxt   = round_q;
    beat_nxt    = beat_q;
    load_csr1   = 1'b0;
    advance_row = 1'b0;
    rot_csr2    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.start) begin
          load_csr1 = 1'b1;
          state_nxt = ST_PRIME;
        end
      end
      ST_PRIME: begin
        advance_row = 1'b1;
        round_nxt   = '0;
        beat_nxt    = '0;
        state_nxt   = ST_STREAM;
      end
      ST_STREAM: begin
        if (accept) begin
          if (beat_q != LAST) begin
            rot_csr2 = 1'b1;
            beat_nxt = beat_q + CW'(1);
          end else if (round_q != LAST) begin
            advance_row = 1'b1;
            beat_nxt    = '0;
            round_nxt   = round_q + CW'(1);
          end else begin
            state_nxt = ST_FIN;
          end
        end
      end
      ST_FIN: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  coeff_rot_reg #(.N(N), .W(W)) u_csr1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_en   (load_csr1),
    .load_data (bus.data_in),
    .rot_en    (advance_row),
    .neg_en    (mode_q == MODE_NEGACYCLIC),
    .q         (csr1_q)
  );

  coeff_rot_reg #(.N(N), .W(W)) u_csr2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_en   (advance_row),
    .load_data (csr1_q),
    .rot_en    (rot_csr2),
    .neg_en    (1'b0),
    .q         (csr2_q)
  );

  assign bus.out_valid = (state == ST_STREAM);
  assign bus.out_data  = csr2_q[(N-1)*W +: W];
  assign bus.out_round = round_q;
  assign bus.out_beat  = beat_q;
  assign bus.out_last  = (state == ST_STREAM) && (round_q == LAST) && (beat_q == LAST);
  assign bus.busy      = (state != ST_IDLE);
  assign bus.done      = (state == ST_FIN);

endmodule

// File: tb/tb_poly_coeff_streamer.sv
// Directed bench for poly_coeff_streamer: a W=2 and a W=3 instance run side by
// side on shared start/mode/ready, checked against hand tables and a row model.
module tb_poly_coeff_streamer;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   testsRun    = 0;
  int   testsFailed = 0;

  int negHand[N*N]  = '{1, 3, 0, 1,  3, 0, 1, 3,  0, 1, 3, 1,  1, 3, 1, 0};
  int cycHand[N*N]  = '{1, 3, 0, 1,  3, 0, 1, 1,  0, 1, 1, 3,  1, 1, 3, 0};
  int noHand[N*N]   = '{-1, -1, -1, -1, -1, -1, -1, -1, -1, -1, -1, -1, -1, -1, -1, -1};
  int opA[N]        = '{1, 0, -1, 1};
  int opB[N]        = '{-2, 1, -1, 0};
  int opWrapLo[N]   = '{-4, 0, 0, 0};
  int opWrapHi[N]   = '{0, 0, 0, -4};
  int opMix3[N]     = '{3, -4, 2, -1};

  always #5 clk = ~clk;

  poly_coeff_streamer_if #(.N(N), .W(2)) bus2 ();
  poly_coeff_streamer_if #(.N(N), .W(3)) bus3 ();

  assign bus3.start     = bus2.start;
  assign bus3.mode      = bus2.mode;
  assign bus3.out_ready = bus2.out_ready;

  poly_coeff_streamer #(.N(N), .W(2)) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2.slave)
  );

  poly_coeff_streamer #(.N(N), .W(3)) dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus3.slave)
  );

  task automatic checkOutput(input string tag, input int got, input int exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Row r of b*x^r: coefficient i comes from b[i-r], negated in negacyclic
  // mode when it wrapped past x^N. Beat k carries coefficient N-1-k.
  function automatic int expCoeff(input int b[N], input bit m, input int r,
                                  input int k, input int w);
    int i, src, v;
    i   = N - 1 - k;
    src = i - r;
    if (src >= 0) v = b[src];
    else          v = m ? -b[src + N] : b[src + N];
    return v & ((1 << w) - 1);
  endfunction

  function automatic logic [3*N-1:0] packOperand(input int b[N], input int w);
    logic [3*N-1:0] d;
    d = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < w; j++)
        d[i*w + j] = b[i][j];
    return d;
  endfunction

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, " valid"}, bus2.out_valid, 0);
    checkOutput({tag, " busy"},  bus2.busy,      0);
    checkOutput({tag, " done"},  bus2.done,      0);
    checkOutput({tag, " data"},  bus2.out_data,  0);
    checkOutput({tag, " round"}, bus2.out_round, 0);
    checkOutput({tag, " beat"},  bus2.out_beat,  0);
    checkOutput({tag, " last"},  bus2.out_last,  0);
    checkOutput({tag, " data3"}, bus3.out_data,  0);
    checkOutput({tag, " busy3"}, bus3.busy,      0);
  endtask

  // Called on a falling edge with the DUTs idle; returns on a falling edge.
  task automatic applyStimulus(input int b2[N], input int b3[N], input bit m,
                               input bit randReady, input int pokeBeat,
                               input int abortBeat, input int hand[N*N]);
    logic [3*N-1:0] p2, p3;
    int cyc, beat, guard, r, k;
    p2 = packOperand(b2, 2);
    p3 = packOperand(b3, 3);
    bus2.data_in   = p2[2*N-1:0];
    bus3.data_in   = p3;
    bus2.mode      = m;
    bus2.start     = 1'b1;
    bus2.out_ready = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      bus2.start = 1'b0;
      cyc++;
    end while (!bus2.out_valid && cyc < 8);
    checkOutput("first valid latency", cyc, 2);

    beat  = 0;
    guard = 0;
    while (beat < N*N && guard < 300) begin
      r = beat / N;
      k = beat % N;
      checkOutput("stream valid", bus2.out_valid, 1);
      checkOutput("stream busy",  bus2.busy, 1);
      checkOutput("data w2", bus2.out_data, expCoeff(b2, m, r, k, 2));
      checkOutput("data w3", bus3.out_data, expCoeff(b3, m, r, k, 3));
      checkOutput("round",   bus2.out_round, r);
      checkOutput("beat",    bus2.out_beat, k);
      checkOutput("last",    bus2.out_last, int'(beat == N*N-1));
      checkOutput("done low in stream", bus2.done, 0);
      if (hand[beat] >= 0) checkOutput("hand table", bus2.out_data, hand[beat]);
      if (beat == abortBeat) begin
        rst_n = 1'b0;
        #1;
        checkResetOutputs("abort");
        @(negedge clk);
        checkOutput("abort no done", bus2.done, 0);
        checkOutput("abort idle",    bus2.busy, 0);
        rst_n = 1'b1;
        return;
      end
      bus2.start = (beat == pokeBeat);
      if (beat == pokeBeat) begin
        bus2.data_in = ~p2[2*N-1:0];
        bus3.data_in = ~p3;
      end
      bus2.out_ready = randReady ? ($urandom_range(0, 1) == 1) : 1'b1;
      if (bus2.out_ready) beat++;
      @(negedge clk);
      guard++;
    end
    bus2.start     = 1'b0;
    bus2.out_ready = 1'b1;
    checkOutput("beats accepted", beat, N*N);
    checkOutput("fin done",  bus2.done, 1);
    checkOutput("fin valid", bus2.out_valid, 0);
    checkOutput("fin busy",  bus2.busy, 1);
    checkOutput("fin done w3", bus3.done, 1);
    @(negedge clk);
    checkOutput("idle done", bus2.done, 0);
    checkOutput("idle busy", bus2.busy, 0);
  endtask

  initial begin
    rst_n          = 1'b0;
    bus2.start     = 1'b0;
    bus2.mode      = 1'b0;
    bus2.out_ready = 1'b0;
    bus2.data_in   = '0;
    bus3.data_in   = '0;
    #12;
    checkResetOutputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    applyStimulus(opA, opWrapLo, 1'b1, 1'b0, -1, -1, negHand);
    applyStimulus(opA, opWrapHi, 1'b0, 1'b0, -1, -1, cycHand);
    applyStimulus(opA, opWrapHi, 1'b1, 1'b1, -1, -1, negHand);
    applyStimulus(opA, opMix3,   1'b1, 1'b0,  5, -1, negHand);
    applyStimulus(opA, opMix3,   1'b1, 1'b0, -1,  9, negHand);
    applyStimulus(opB, opMix3,   1'b1, 1'b0, -1, -1, noHand);
    applyStimulus(opB, opMix3,   1'b0, 1'b1, -1, -1, noHand);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
